regfile_sb: RTL and testbench



---
 rtl/regfile_sb_if.sv | 29 ++
 rtl/regfile_sb.sv | 82 ++++++++
 tb/tb_regfile_sb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, write port, reserve port and scoreboard view.
// master = decode/issue/writeback side, slave = register file.
interface regfile_sb_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   i_rs_addr;
    logic [NREAD*XLEN-1:0] o_rs_data;
    logic [NREAD-1:0]      o_rs_busy;
    logic                  i_wen;
    logic [AW-1:0]         i_wd_addr;
    logic [XLEN-1:0]       i_wdata;
    logic                  i_rsv_en;
    logic [AW-1:0]         i_rsv_addr;
    logic [NREGS-1:0]      o_busy_vec;

    modport master (
        output i_rs_addr, i_wen, i_wd_addr, i_wdata, i_rsv_en, i_rsv_addr,
        input  o_rs_data, o_rs_busy, o_busy_vec
    );

    modport slave (
        input  i_rs_addr, i_wen, i_wd_addr, i_wdata, i_rsv_en, i_rsv_addr,
        output o_rs_data, o_rs_busy, o_busy_vec
    );
endinterface

// File: rtl/regfile_sb.sv
// Flop-based register file with pending-write scoreboard; combinational reads (0 cycles),
// writes/reserves take effect at the next edge; no backpressure, every request is accepted.
module regfile_sb #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wr_ok;
    logic             rsv_ok;
    logic [AW-1:0]    rd_addr [NREAD];

    assign wr_ok  = bus.i_wen    && !(ZR && (bus.i_wd_addr  == '0));
    assign rsv_ok = bus.i_rsv_en && !(ZR && (bus.i_rsv_addr == '0));

    // Reserve is applied after the write so a newer issue keeps ownership of the destination.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[bus.i_wd_addr] = bus.i_wdata;
            busy_d[bus.i_wd_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[bus.i_rsv_addr] = 1'b1;
        end
        if (ZR) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NREAD; k++) begin
            rd_addr[k] = bus.i_rs_addr[k*AW +: AW];
        end
    end

    // Same-cycle write clears the hazard; a same-cycle reserve is only seen next cycle.
    always_comb begin
        bus.o_rs_data = '0;
        bus.o_rs_busy = '0;
        for (int k = 0; k < NREAD; k++) begin
            if (!i_rst && !(ZR && (rd_addr[k] == '0))) begin
                if (BP && wr_ok && (bus.i_wd_addr == rd_addr[k])) begin
                    bus.o_rs_data[k*XLEN +: XLEN] = bus.i_wdata;
                    bus.o_rs_busy[k]              = 1'b0;
                end else begin
                    bus.o_rs_data[k*XLEN +: XLEN] = regs_q[rd_addr[k]];
                    bus.o_rs_busy[k]              = busy_q[rd_addr[k]];
                end
            end
        end
    end

    assign bus.o_busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks on the default and no-bypass builds, then random traffic on a 16x32, 3-port build.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(64), .NREGS(32), .NREAD(2)) b0 ();
    regfile_sb_if #(.XLEN(64), .NREGS(32), .NREAD(2)) b1 ();
    regfile_sb_if #(.XLEN(32), .NREGS(16), .NREAD(3)) b2 ();

    regfile_sb #(.XLEN(64), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1))
        u0 (.i_clk(clk), .i_rst(rst), .bus(b0));
    regfile_sb #(.XLEN(64), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0))
        u1 (.i_clk(clk), .i_rst(rst), .bus(b1));
    regfile_sb #(.XLEN(32), .NREGS(16), .NREAD(3), .ZERO_REG(1), .BYPASS(1))
        u2 (.i_clk(clk), .i_rst(rst), .bus(b2));

    int checks = 0;
    int errors = 0;
    string       tag_q [$];
    logic [63:0] exp_q [$];

    logic [31:0] m_reg  [16];
    logic [15:0] m_busy;

    task automatic push(input string tag, input logic [63:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b0.i_rs_addr = '0; b0.i_wen = 0; b0.i_wd_addr = '0; b0.i_wdata = '0;
        b0.i_rsv_en = 0; b0.i_rsv_addr = '0;
        b1.i_rs_addr = '0; b1.i_wen = 0; b1.i_wd_addr = '0; b1.i_wdata = '0;
        b1.i_rsv_en = 0; b1.i_rsv_addr = '0;
        b2.i_rs_addr = '0; b2.i_wen = 0; b2.i_wd_addr = '0; b2.i_wdata = '0;
        b2.i_rsv_en = 0; b2.i_rsv_addr = '0;
    endtask

    // Read both ports of u0 and compare data/busy against expectations.
    task automatic rd0(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] bz);
        b0.i_rs_addr = {a1, a0};
        push({tag, "_d0"}, d0);
        push({tag, "_d1"}, d1);
        push({tag, "_busy"}, {62'd0, bz});
        #1;
        pop_cmp(b0.o_rs_data[63:0]);
        pop_cmp(b0.o_rs_data[127:64]);
        pop_cmp({62'd0, b0.o_rs_busy});
    endtask

    task automatic bv0(input string tag, input logic [31:0] e);
        push(tag, {32'd0, e});
        #1;
        pop_cmp({32'd0, b0.o_busy_vec});
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        rd0("rst_comb", 5'd5, 5'd7, 64'd0, 64'd0, 2'b00);
        step();
        rst = 1'b0;

        // After reset every register reads zero and nothing is pending
        for (int r = 0; r < 32; r++) begin
            rd0("reset_rd", 5'(r), 5'(31 - r), 64'd0, 64'd0, 2'b00);
        end
        bv0("reset_bv", 32'd0);

        b0.i_wen = 1; b0.i_wd_addr = 5'd5; b0.i_wdata = 64'hDEAD_BEEF_0123_4567;
        step();
        b0.i_wen = 0;
        rd0("wr_x5", 5'd5, 5'd0, 64'hDEAD_BEEF_0123_4567, 64'd0, 2'b00);

        // Reserve x7, then watch the bypassed write clear the hazard
        b0.i_rsv_en = 1; b0.i_rsv_addr = 5'd7;
        step();
        b0.i_rsv_en = 0;
        rd0("rsv_x7", 5'd5, 5'd7, 64'hDEAD_BEEF_0123_4567, 64'd0, 2'b10);
        bv0("rsv_x7_bv", 32'h0000_0080);
        b0.i_wen = 1; b0.i_wd_addr = 5'd7; b0.i_wdata = 64'h1234;
        rd0("byp_x7", 5'd5, 5'd7, 64'hDEAD_BEEF_0123_4567, 64'h1234, 2'b00);
        step();
        b0.i_wen = 0;
        bv0("x7_clr_bv", 32'd0);
        rd0("x7_after", 5'd7, 5'd7, 64'h1234, 64'h1234, 2'b00);

        // Same-edge write and reserve of x9: read sees bypass now, busy afterwards
        b0.i_wen = 1; b0.i_wd_addr = 5'd9; b0.i_wdata = 64'hAA;
        b0.i_rsv_en = 1; b0.i_rsv_addr = 5'd9;
        rd0("wr_rsv_x9_now", 5'd9, 5'd7, 64'hAA, 64'h1234, 2'b00);
        step();
        idle();
        rd0("wr_rsv_x9", 5'd9, 5'd9, 64'hAA, 64'hAA, 2'b11);
        bv0("wr_rsv_x9_bv", 32'h0000_0200);

        // x0 ignores writes and reserves
        b0.i_wen = 1; b0.i_wd_addr = 5'd0; b0.i_wdata = 64'hFFFF;
        b0.i_rsv_en = 1; b0.i_rsv_addr = 5'd0;
        rd0("x0_now", 5'd0, 5'd0, 64'd0, 64'd0, 2'b00);
        step();
        idle();
        rd0("x0_after", 5'd0, 5'd9, 64'd0, 64'hAA, 2'b10);
        bv0("x0_bv", 32'h0000_0200);

        // No-bypass build: a write is visible only after its edge
        b1.i_wen = 1; b1.i_wd_addr = 5'd3; b1.i_wdata = 64'h55; b1.i_rs_addr = {5'd0, 5'd3};
        push("nobyp_now", 64'd0);
        #1;
        pop_cmp(b1.o_rs_data[63:0]);
        step();
        b1.i_wen = 0;
        push("nobyp_next", 64'h55);
        #1;
        pop_cmp(b1.o_rs_data[63:0]);

        // Reset discards a concurrent write
        b0.i_rsv_en = 1; b0.i_rsv_addr = 5'd4;
        step();
        b0.i_rsv_addr = 5'd6;
        step();
        b0.i_rsv_en = 0;
        b0.i_wen = 1; b0.i_wd_addr = 5'd4; b0.i_wdata = 64'h77;
        step();
        bv0("pre_rst_bv", 32'h0000_0240);
        rd0("pre_rst_rd", 5'd4, 5'd6, 64'h77, 64'd0, 2'b10);
        rst = 1'b1;
        b0.i_wen = 1; b0.i_wd_addr = 5'd6; b0.i_wdata = 64'h99;
        rd0("in_rst_rd", 5'd4, 5'd5, 64'd0, 64'd0, 2'b00);
        step();
        rst = 1'b0;
        idle();
        bv0("post_rst_bv", 32'd0);
        rd0("post_rst_rd", 5'd4, 5'd6, 64'd0, 64'd0, 2'b00);
        rd0("post_rst_rd2", 5'd5, 5'd9, 64'd0, 64'd0, 2'b00);

        // Random traffic on the 3-port build against a reference model
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_busy = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [3:0] a;
            rst = ($urandom_range(0, 39) == 0);
            b2.i_wen      = $urandom_range(0, 1) == 1;
            b2.i_wd_addr  = 4'($urandom);
            b2.i_wdata    = $urandom;
            b2.i_rsv_en   = $urandom_range(0, 2) == 0;
            b2.i_rsv_addr = 4'($urandom);
            b2.i_rs_addr  = 12'($urandom);
            if ($urandom_range(0, 3) == 0) b2.i_rs_addr[3:0] = b2.i_wd_addr;
            for (int k = 0; k < 3; k++) begin
                a = b2.i_rs_addr[k*4 +: 4];
                if (rst || a == 4'd0) begin
                    push("rnd_d", 64'd0);
                    push("rnd_b", 64'd0);
                end else if (b2.i_wen && b2.i_wd_addr == a) begin
                    push("rnd_d", {32'd0, b2.i_wdata});
                    push("rnd_b", 64'd0);
                end else begin
                    push("rnd_d", {32'd0, m_reg[a]});
                    push("rnd_b", {63'd0, m_busy[a]});
                end
            end
            push("rnd_bv", {48'd0, m_busy});
            #1;
            for (int k = 0; k < 3; k++) begin
                pop_cmp({32'd0, b2.o_rs_data[k*32 +: 32]});
                pop_cmp({63'd0, b2.o_rs_busy[k]});
            end
            pop_cmp({48'd0, b2.o_busy_vec});
            if (rst) begin
                for (int i = 0; i < 16; i++) m_reg[i] = '0;
                m_busy = '0;
            end else begin
                if (b2.i_wen && b2.i_wd_addr != 4'd0) begin
                    m_reg[b2.i_wd_addr]  = b2.i_wdata;
                    m_busy[b2.i_wd_addr] = 1'b0;
                end
                if (b2.i_rsv_en && b2.i_rsv_addr != 4'd0) m_busy[b2.i_rsv_addr] = 1'b1;
            end
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
